sc_mac_bi_param: RTL and testbench
==================================

# sc_mac_bi_param

Parametrised bipolar stochastic multiply-accumulate unit with mux-based scaled addition and a start/done handshake. It computes sum(A_i·B_i)/NCH over NCH channels as one bipolar bit-stream of length 2^DW, using internal low-discrepancy RNGs. An optional ones-counter converts the stream back to binary. It is the configurable successor to the fixed 16-channel, 8-bit MAC16 stochastic MAC and sits in the same SC datapath layer.

## Interface
- NCH, 16, channel count; power of two, 2..64
- DW, 8, operand width; stream length L = 2^DW; 4..10
- SW, $clog2(NCH), select width (derived, not overridable)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- iA  in  [NCH][DW]  bipolar operands A, offset-binary (value = 2·x/2^DW − 1)
- iB  in  [NCH][DW]  bipolar operands B, offset-binary
- start  in  1  request a new stream; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start through the DRAIN state
- oValid  out  1  oC carries a stream bit this cycle
- oC  out  1  output bipolar stream bit
- done  out  1  one-cycle pulse after the last stream bit
- oOnes  out  DW+1  ones count of the last stream; present only with SC_MAC_CNT_EN

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE with start=1: latch all iA/iB into operand registers, clear cnt (DW bits) and the ones counter, go to RUN. iA/iB are ignored at all other times.
- RUN: lasts L cycles, with cnt = 0..L−1. Per cycle:
  - rngA = bitreverse(cnt)
  - rngB = cnt
  - a_i = (A_i > rngA), b_i = (B_i > rngB), strict unsigned compare
  - p_i = a_i XNOR b_i, the bipolar product
  - sel = bitreverse(cnt[SW−1:0]), so each channel is selected exactly L/NCH times per stream
  - p_sel is registered into oC with oValid=1.
  - cnt = L−1 goes to DRAIN.
- DRAIN: one cycle. The last registered bit is visible on oC/oValid. No new products are computed.
- DONE: one cycle with done=1, oValid=0. Then IDLE.
- start outside IDLE, including in DONE, is ignored and not queued.
- Result semantics: ones/L maps to bipolar (2·ones/L − 1) = (1/NCH)·Σ A_i·B_i (bipolar), within SC error.
- Reset, including mid-stream: state IDLE, cnt=0, operand registers 0, oC=0, oValid=0, busy=0, done=0, oOnes=0. A stream in progress is discarded.

## Timing
- Cycle 0 is start sampled in IDLE.
- Cycles 1..L: RUN, busy=1.
- Cycles 2..L+1: oValid=1, one bit per cycle.
- Latency from start to the first bit is 2 cycles.
- Cycle L+1: DRAIN.
- Cycle L+2: done=1, busy=0. oOnes is final and held until the next accepted start clears it.
- Minimum start-to-start spacing is L+3 cycles.

## Configuration
- SC_MAC_CNT_EN defined:
  - The ones counter (DW+1 bits, saturation impossible) increments on each oValid & oC.
  - oOnes is exposed and valid from the done cycle onward.
- SC_MAC_CNT_EN undefined:
  - The counter and the oOnes port are absent.
  - The stream-only behaviour is otherwise identical.

## Structure
- Shared package sc_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE)
  - a bitreverse function parametrised on width
  - the offset-binary constants (bipolar zero = 2^(DW−1))
- Natural sub-module: sc_gmul_bi_lane. It holds one channel's operand registers, comparators and XNOR, and is instantiated NCH times via generate.
- The mux, FSM, cnt and optional counter stay in the top module.

## Test plan
- Reset mid-RUN at cnt=100 → next cycle all outputs 0, state IDLE. A start 2 cycles later yields a full 256-bit stream.
- DW=8, NCH=16, all iA=iB=255, start → oValid high for exactly 256 cycles (cycles 2..257), all oC=1, done at cycle 258, oOnes=256.
- All iA=iB=128 (bipolar 0) → oOnes=128.
- All iA=255, iB=0 → oOnes=1, a single 1 at cnt=255.
- Channels 0..7 iA=iB=255, channels 8..15 iA=255 and iB=0 → oOnes=129, which is bipolar ≈ 0.
- start held high through RUN and DONE → exactly one stream per IDLE entry. start during RUN is ignored, and busy/done follow the timing above.

Source files
------------

// File: rtl/sc_mac_bi_param_pkg.sv
// sc_pkg: definitions shared by the sc_mac_bi_param slice.
//   state_t       - FSM states of the stream sequencer
//   bitreverse()  - reverses the low w bits of a vector; w = 1..MAX_W
//   bipolar_zero()- offset-binary code of bipolar 0 for a given width
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Widest vector bitreverse() handles; covers DW up to 10 and SW up to 6.
  localparam int MAX_W = 16;

  // Reverse all MAX_W bits, then shift so that the reversed low w bits land
  // in [w-1:0]. Bits above w come out zero, so callers can size-cast freely.
  function automatic logic [MAX_W-1:0] bitreverse(input logic [MAX_W-1:0] v,
                                                  input int w);
    logic [MAX_W-1:0] full;
    full = '0;
    for (int i = 0; i < MAX_W; i++) full[i] = v[MAX_W-1-i];
    return full >> (MAX_W - w);
  endfunction

  // In offset binary, value = 2*x/2^dw - 1, so bipolar 0 is 2^(dw-1).
  function automatic int bipolar_zero(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/sc_mac_bi_param_if.sv
// sc_mac_bi_param_if: operand / handshake / stream bundle of sc_mac_bi_param.
//   iA, iB  [NCH][DW] offset-binary bipolar operands (master -> slave)
//   start             stream request (master -> slave)
//   busy, oValid, oC, done  status and output stream (slave -> master)
//   oOnes   [DW:0]    ones count of the last stream, only with SC_MAC_CNT_EN
interface sc_mac_bi_param_if #(
  parameter int NCH = 16,
  parameter int DW  = 8
);
  logic [NCH-1:0][DW-1:0] iA;
  logic [NCH-1:0][DW-1:0] iB;
  logic                   start;
  logic                   busy;
  logic                   oValid;
  logic                   oC;
  logic                   done;
`ifdef SC_MAC_CNT_EN
  logic [DW:0]            oOnes;
`endif

  modport master (
    output iA, iB, start,
    input  busy, oValid, oC, done
`ifdef SC_MAC_CNT_EN
    , input oOnes
`endif
  );

  modport slave (
    input  iA, iB, start,
    output busy, oValid, oC, done
`ifdef SC_MAC_CNT_EN
    , output oOnes
`endif
  );
endinterface

// File: rtl/sc_gmul_bi_lane.sv
// sc_gmul_bi_lane: one channel of the bipolar stochastic multiplier.
// Holds the channel's operand registers, converts each to a bit-stream by
// strict comparison against its RNG, and multiplies the two bipolar streams
// with an XNOR.
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture a_in/b_in into the operand registers
//   a_in, b_in    offset-binary operands
//   rng_a, rng_b  per-cycle random numbers for A and B
//   p             bipolar product bit for this cycle
module sc_gmul_bi_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [DW-1:0] rng_a,
  input  logic [DW-1:0] rng_b,
  output logic          p
);
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  // NOTE: operand registers sit on the reset net on purpose: a reset must
  // leave them at 0, not at whatever the previous stream loaded. State is
  // updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end
  end

  assign p = ~((a_q > rng_a) ^ (b_q > rng_b));
endmodule

// File: rtl/sc_mac_bi_param.sv
// sc_mac_bi_param: parametrised bipolar stochastic MAC.
// Produces one bipolar stream of length 2^DW encoding sum(A_i*B_i)/NCH by
// selecting one channel product per cycle (mux-based scaled addition).
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sc_mac_bi_param_if.slave: iA, iB, start in; busy, oValid,
//               oC, done (and oOnes) out
// Optional feature: define SC_MAC_CNT_EN to add the DW+1 bit ones counter
// and the oOnes output.
module sc_mac_bi_param
  import sc_pkg::*;
#(
  parameter int NCH = 16,
  parameter int DW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sc_mac_bi_param_if.slave   bus
);
  localparam int SW = $clog2(NCH);

  state_t           state_q, state_d;
  logic             accept;
  logic [DW-1:0]    cnt_q;
  logic [MAX_W-1:0] cnt_ext;
  logic [DW-1:0]    rng_a;
  logic [DW-1:0]    rng_b;
  logic [SW-1:0]    sel;
  logic [NCH-1:0]   prod;
  logic             oc_q;
  logic             ovalid_q;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:     if (&cnt_q) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // cnt wraps back to 0 on its last RUN cycle, ready for the next stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (accept)           cnt_q <= '0;
    else if (state_q == RUN)   cnt_q <= cnt_q + 1'b1;
  end

  // Low-discrepancy RNGs: A sees the bit-reversed count (van der Corput),
  // B the plain count, so the two streams stay decorrelated.
  assign cnt_ext = MAX_W'(cnt_q);
  assign rng_a   = DW'(bitreverse(cnt_ext, DW));
  assign rng_b   = cnt_q;
  // Bit-reversed low bits visit every channel once per NCH cycles and
  // spread each channel's picks evenly over the stream.
  assign sel     = SW'(bitreverse(cnt_ext, SW));

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    sc_gmul_bi_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .a_in  (bus.iA[g]),
      .b_in  (bus.iB[g]),
      .rng_a (rng_a),
      .rng_b (rng_b),
      .p     (prod[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_q     <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      ovalid_q <= (state_q == RUN);
      oc_q     <= (state_q == RUN) & prod[sel];
    end
  end

  assign bus.oC     = oc_q;
  assign bus.oValid = ovalid_q;
  assign bus.busy   = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done   = (state_q == DONE);

`ifdef SC_MAC_CNT_EN
  // DW+1 bits hold up to 2^DW, the most ones a stream can carry.
  logic [DW:0] ones_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ones_q <= '0;
    else if (accept)             ones_q <= '0;
    else if (ovalid_q && oc_q)   ones_q <= ones_q + 1'b1;
  end

  assign bus.oOnes = ones_q;
`endif
endmodule

// File: tb/tb_sc_mac_bi_param.sv
// Directed bench for sc_mac_bi_param (NCH=16, DW=8). Expected ones counts
// and cycle positions are hand-derived constants; the stream is counted
// from oValid/oC, and oOnes is also checked when SC_MAC_CNT_EN is defined.
module tb_sc_mac_bi_param;
  import sc_pkg::*;

  localparam int NCH = 16;
  localparam int DW  = 8;
  localparam int L   = 1 << DW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sc_mac_bi_param_if #(.NCH(NCH), .DW(DW)) bus ();

  sc_mac_bi_param #(.NCH(NCH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Channels below NCH/2 get (a_lo, b_lo), the rest (a_hi, b_hi).
  task automatic set_ops(input logic [DW-1:0] a_lo, input logic [DW-1:0] b_lo,
                         input logic [DW-1:0] a_hi, input logic [DW-1:0] b_hi);
    for (int ch = 0; ch < NCH; ch++) begin
      bus.iA[ch] = (ch < NCH / 2) ? a_lo : a_hi;
      bus.iB[ch] = (ch < NCH / 2) ? b_lo : b_hi;
    end
  endtask

  // Issues one start and observes cycles 1..L+3 (cycle 0 = start sampled).
  // With hold set, start stays high for the whole window.
  task automatic run_stream(input string tag, input int exp_ones, input bit hold,
                            output int last_one);
    int ones     = 0;
    int nvalid   = 0;
    int first_v  = -1;
    int last_v   = -1;
    int ndone    = 0;
    int done_cyc = -1;
    int nbusy    = 0;
    last_one = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= L + 3; cyc++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.oValid) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (bus.oC) begin
          ones++;
          last_one = cyc;
        end
      end
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
`ifdef SC_MAC_CNT_EN
        check({tag, "_oOnes"}, int'(bus.oOnes), exp_ones);
`endif
      end
      if (bus.busy) nbusy++;
    end
    check({tag, "_ones"},     ones,     exp_ones);
    check({tag, "_nvalid"},   nvalid,   L);
    check({tag, "_first_v"},  first_v,  2);
    check({tag, "_last_v"},   last_v,   L + 1);
    check({tag, "_ndone"},    ndone,    1);
    check({tag, "_done_cyc"}, done_cyc, L + 2);
    check({tag, "_nbusy"},    nbusy,    L + 1);
  endtask

  initial begin
    int last_one;
    bit seen;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_ops('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_ovalid", int'(bus.oValid), 0);
    check("rst_oc",     int'(bus.oC),     0);
    check("rst_done",   int'(bus.done),   0);
    rst_n = 1'b1;
    @(negedge clk);

    // All +1 * +1: every product bit is 1.
    set_ops(8'd255, 8'd255, 8'd255, 8'd255);
    run_stream("all_one", 256, 1'b0, last_one);

    // Bipolar 0 * 0: half the bits set.
    set_ops(8'd128, 8'd128, 8'd128, 8'd128);
    run_stream("zero", 128, 1'b0, last_one);

    // +1 * -1: only cnt=255 gives a 1, which is the last bit (cycle L+1).
    set_ops(8'd255, 8'd0, 8'd255, 8'd0);
    run_stream("neg", 1, 1'b0, last_one);
    check("neg_last_one", last_one, L + 1);

    // Half the channels +1, half -1: bipolar ~0.
    set_ops(8'd255, 8'd255, 8'd255, 8'd0);
    run_stream("mixed", 129, 1'b0, last_one);

    // Reset while RUN has cnt=100 (cycle 101).
    set_ops(8'd255, 8'd255, 8'd255, 8'd255);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 101; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   int'(bus.busy),   0);
    check("mid_rst_ovalid", int'(bus.oValid), 0);
    check("mid_rst_oc",     int'(bus.oC),     0);
    check("mid_rst_done",   int'(bus.done),   0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_busy",   int'(bus.busy),   0);
    check("post_rst_ovalid", int'(bus.oValid), 0);
    run_stream("after_rst", 256, 1'b0, last_one);

    // start held high: exactly one stream per IDLE entry.
    set_ops(8'd128, 8'd128, 8'd128, 8'd128);
    run_stream("hold", 128, 1'b1, last_one);
    @(negedge clk);
    check("hold_restart_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < L + 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_second_done", int'(seen), 1);
    @(negedge clk);
    check("hold_end_busy", int'(bus.busy), 0);
    check("hold_end_done", int'(bus.done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
